// File: rtl/hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forwarding
// selects, pipe-control bundles and the register-match helper.
package hazard_controller_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_enable;
    logic ifid_enable;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_OFF      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_STALL    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam pipe_ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  // A producer only matters if it writes a real register; $zero is never forwarded.
  function automatic logic reg_match(input logic       write,
                                     input logic [4:0] rd,
                                     input logic [4:0] src);
    return write && (rd != REG_ZERO) && (rd == src);
  endfunction

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// Operand forwarding select for one ALU input; the youngest producer (EX/MEM) wins.
module forward_unit
  import hazard_controller_pkg::*;
(
  input  logic [4:0] src,
  input  logic       exmem_reg_write,
  input  logic [4:0] exmem_rd,
  input  logic       memwb_reg_write,
  input  logic [4:0] memwb_rd,
  output logic [1:0] sel
);

  // NOTE: sel gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    sel = FWD_RF;
    if (reg_match(exmem_reg_write, exmem_rd, src)) begin
      sel = FWD_EXMEM;
    end else if (reg_match(memwb_reg_write, memwb_rd, src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall FSM, redirect flushing, operand
// forwarding and saturating stall/redirect event counters.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_uses_rt,
  input  logic [4:0]           ex_rs,
  input  logic [4:0]           ex_rt,
  input  logic                 idex_mem_read,
  input  logic [4:0]           idex_rd,
  input  logic                 exmem_reg_write,
  input  logic [4:0]           exmem_rd,
  input  logic                 memwb_reg_write,
  input  logic [4:0]           memwb_rd,
  input  logic                 redirect,
  input  logic                 cnt_clear,
  output logic                 pc_enable,
  output logic                 ifid_enable,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 exmem_flush,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] redirect_count
);

  localparam logic [1:0]           STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  state_e     state;
  logic [1:0] scnt;
  logic       lu;
  logic       stall_resp;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  pipe_ctrl_t ctrl;

  forward_unit u_fwd_a (
    .src             (ex_rs),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .sel             (fwd_a_sel)
  );

  forward_unit u_fwd_b (
    .src             (ex_rt),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .sel             (fwd_b_sel)
  );

  assign lu = reg_match(idex_mem_read, idex_rd, id_rs) |
              reg_match(idex_mem_read & id_uses_rt, idex_rd, id_rt);

  // Once in STALL the bubble count is fixed; a redirect always overrides the stall.
  assign stall_resp = !redirect && ((state == STALL) || lu);

  always_comb begin
    ctrl = CTRL_RUN;
    if (!reset) begin
      ctrl = CTRL_OFF;
    end else if (redirect) begin
      ctrl = CTRL_REDIRECT;
    end else if (stall_resp) begin
      ctrl = CTRL_STALL;
    end
  end

  assign {pc_enable, ifid_enable, ifid_flush, idex_flush, exmem_flush} = ctrl;
  assign fwd_a = reset ? fwd_a_sel : FWD_RF;
  assign fwd_b = reset ? fwd_b_sel : FWD_RF;
  assign busy  = (state == STALL);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      scnt  <= 2'd0;
    end else if (redirect) begin
      state <= RUN;
      scnt  <= 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (lu && (LOAD_STALL_CYCLES > 1)) begin
            state <= STALL;
            scnt  <= STALL_INIT;
          end
        end
        STALL: begin
          scnt <= scnt - 2'd1;
          if (scnt == 2'd1) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
          scnt  <= 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count    <= '0;
      redirect_count <= '0;
    end else if (cnt_clear) begin
      stall_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (stall_resp && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_WIDTH'(1);
      end
      if (redirect && (redirect_count != CNT_MAX)) begin
        redirect_count <= redirect_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: two instances (1-cycle / 3-cycle stalls,
// 16-bit / 4-bit counters) share stimulus; a monitor pops hand-computed expectations.
module tb_hazard_controller;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, idex_rd, exmem_rd, memwb_rd;
  logic id_uses_rt, idex_mem_read, exmem_reg_write, memwb_reg_write, redirect, cnt_clear;
  logic smp = 1'b0;

  logic        pc_enable_1, ifid_enable_1, ifid_flush_1, idex_flush_1, exmem_flush_1, busy_1;
  logic [1:0]  fwd_a_1, fwd_b_1;
  logic [15:0] stall_count_1, redirect_count_1;
  logic        pc_enable_3, ifid_enable_3, ifid_flush_3, idex_flush_3, exmem_flush_3, busy_3;
  logic [1:0]  fwd_a_3, fwd_b_3;
  logic [3:0]  stall_count_3, redirect_count_3;

  localparam logic [4:0] C_OFF   = 5'b00000;
  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_STALL = 5'b00010;
  localparam logic [4:0] C_REDIR = 5'b11111;

  typedef struct {
    string      name;
    int         dut;
    logic [4:0] ctrl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       busy;
    int         sc;
    int         rc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_controller #(.LOAD_STALL_CYCLES(1), .CNT_WIDTH(16)) u1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .redirect(redirect), .cnt_clear(cnt_clear),
    .pc_enable(pc_enable_1), .ifid_enable(ifid_enable_1), .ifid_flush(ifid_flush_1),
    .idex_flush(idex_flush_1), .exmem_flush(exmem_flush_1),
    .fwd_a(fwd_a_1), .fwd_b(fwd_b_1), .busy(busy_1),
    .stall_count(stall_count_1), .redirect_count(redirect_count_1)
  );

  hazard_controller #(.LOAD_STALL_CYCLES(3), .CNT_WIDTH(4)) u3 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .redirect(redirect), .cnt_clear(cnt_clear),
    .pc_enable(pc_enable_3), .ifid_enable(ifid_enable_3), .ifid_flush(ifid_flush_3),
    .idex_flush(idex_flush_3), .exmem_flush(exmem_flush_3),
    .fwd_a(fwd_a_3), .fwd_b(fwd_b_3), .busy(busy_3),
    .stall_count(stall_count_3), .redirect_count(redirect_count_3)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input int dut, input logic [4:0] ctrl,
                            input logic [1:0] fa, input logic [1:0] fb, input logic busy,
                            input int sc, input int rc);
    exp_t e;
    e.name = $sformatf("%s/u%0d", nm, dut);
    e.dut  = dut;
    e.ctrl = ctrl;
    e.fa   = fa;
    e.fb   = fb;
    e.busy = busy;
    e.sc   = sc;
    e.rc   = rc;
    sb.push_back(e);
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_rs = 5'd0; ex_rt = 5'd0;
    idex_mem_read = 1'b0; idex_rd = 5'd0; exmem_reg_write = 1'b0; exmem_rd = 5'd0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; redirect = 1'b0; cnt_clear = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples mid-cycle (or on an explicit strobe) and drains the scoreboard.
  initial begin
    exp_t        e;
    logic [4:0]  a_ctrl;
    logic [1:0]  a_fa, a_fb;
    logic        a_busy;
    logic [15:0] a_sc, a_rc;
    forever begin
      @(negedge clk or posedge smp);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.dut == 1) begin
          a_ctrl = {pc_enable_1, ifid_enable_1, ifid_flush_1, idex_flush_1, exmem_flush_1};
          a_fa = fwd_a_1; a_fb = fwd_b_1; a_busy = busy_1;
          a_sc = stall_count_1; a_rc = redirect_count_1;
        end else begin
          a_ctrl = {pc_enable_3, ifid_enable_3, ifid_flush_3, idex_flush_3, exmem_flush_3};
          a_fa = fwd_a_3; a_fb = fwd_b_3; a_busy = busy_3;
          a_sc = 16'(stall_count_3); a_rc = 16'(redirect_count_3);
        end
        check({e.name, ".ctrl"},           32'(a_ctrl), 32'(e.ctrl));
        check({e.name, ".fwd_a"},          32'(a_fa),   32'(e.fa));
        check({e.name, ".fwd_b"},          32'(a_fb),   32'(e.fb));
        check({e.name, ".busy"},           32'(a_busy), 32'(e.busy));
        check({e.name, ".stall_count"},    32'(a_sc),   32'(e.sc));
        check({e.name, ".redirect_count"}, 32'(a_rc),   32'(e.rc));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    idle();
    ex_rs = 5'd5; ex_rt = 5'd5;
    exmem_reg_write = 1'b1; exmem_rd = 5'd5;
    memwb_reg_write = 1'b1; memwb_rd = 5'd5;

    // Reset holds every output low even with matching forwarding inputs.
    next_cycle();
    expect_out("reset", 1, C_OFF, 2'b00, 2'b00, 1'b0, 0, 0);
    expect_out("reset", 3, C_OFF, 2'b00, 2'b00, 1'b0, 0, 0);

    next_cycle(); reset = 1'b1;
    expect_out("fwd_both_exmem", 1, C_RUN, 2'b10, 2'b10, 1'b0, 0, 0);
    expect_out("fwd_both_exmem", 3, C_RUN, 2'b10, 2'b10, 1'b0, 0, 0);

    next_cycle(); exmem_rd = 5'd0;
    expect_out("fwd_exmem_r0", 1, C_RUN, 2'b01, 2'b01, 1'b0, 0, 0);
    expect_out("fwd_exmem_r0", 3, C_RUN, 2'b01, 2'b01, 1'b0, 0, 0);

    next_cycle(); exmem_rd = 5'd7; ex_rs = 5'd7;
    expect_out("fwd_split", 1, C_RUN, 2'b10, 2'b01, 1'b0, 0, 0);
    expect_out("fwd_split", 3, C_RUN, 2'b10, 2'b01, 1'b0, 0, 0);

    next_cycle(); exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
    expect_out("fwd_no_write", 1, C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);
    expect_out("fwd_no_write", 3, C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);

    next_cycle(); idle();
    idex_mem_read = 1'b1; idex_rd = 5'd4; id_rt = 5'd4; id_uses_rt = 1'b0; id_rs = 5'd9;
    expect_out("lu_rt_unused", 1, C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);
    expect_out("lu_rt_unused", 3, C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);

    next_cycle(); idle(); idex_mem_read = 1'b1;
    expect_out("lu_reg_zero", 1, C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);
    expect_out("lu_reg_zero", 3, C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);

    next_cycle(); idle();
    idex_mem_read = 1'b1; idex_rd = 5'd4; id_rt = 5'd4; id_uses_rt = 1'b1;
    expect_out("lu_stall1", 1, C_STALL, 2'b00, 2'b00, 1'b0, 0, 0);
    expect_out("lu_stall1", 3, C_STALL, 2'b00, 2'b00, 1'b0, 0, 0);

    next_cycle(); idle();
    expect_out("lu_stall2", 1, C_RUN,   2'b00, 2'b00, 1'b0, 1, 0);
    expect_out("lu_stall2", 3, C_STALL, 2'b00, 2'b00, 1'b1, 1, 0);

    next_cycle();
    expect_out("lu_stall3", 1, C_RUN,   2'b00, 2'b00, 1'b0, 1, 0);
    expect_out("lu_stall3", 3, C_STALL, 2'b00, 2'b00, 1'b1, 2, 0);

    next_cycle();
    expect_out("lu_done", 1, C_RUN, 2'b00, 2'b00, 1'b0, 1, 0);
    expect_out("lu_done", 3, C_RUN, 2'b00, 2'b00, 1'b0, 3, 0);

    next_cycle(); cnt_clear = 1'b1;
    expect_out("clear", 1, C_RUN, 2'b00, 2'b00, 1'b0, 1, 0);
    expect_out("clear", 3, C_RUN, 2'b00, 2'b00, 1'b0, 3, 0);

    next_cycle(); idle(); idex_mem_read = 1'b1; idex_rd = 5'd8; id_rs = 5'd8;
    expect_out("redir_stall1", 1, C_STALL, 2'b00, 2'b00, 1'b0, 0, 0);
    expect_out("redir_stall1", 3, C_STALL, 2'b00, 2'b00, 1'b0, 0, 0);

    // Redirect beats both a pending load-use and an active stall.
    next_cycle(); redirect = 1'b1;
    expect_out("redir_in_stall", 1, C_REDIR, 2'b00, 2'b00, 1'b0, 1, 0);
    expect_out("redir_in_stall", 3, C_REDIR, 2'b00, 2'b00, 1'b1, 1, 0);

    next_cycle(); idle();
    expect_out("redir_after", 1, C_RUN, 2'b00, 2'b00, 1'b0, 1, 1);
    expect_out("redir_after", 3, C_RUN, 2'b00, 2'b00, 1'b0, 1, 1);

    for (int i = 0; i < 20; i++) begin
      next_cycle(); idle(); redirect = 1'b1;
      expect_out($sformatf("redir_run%0d", i), 1, C_REDIR, 2'b00, 2'b00, 1'b0, 1, i + 1);
      expect_out($sformatf("redir_run%0d", i), 3, C_REDIR, 2'b00, 2'b00, 1'b0, 1,
                 (i + 1 > 15) ? 15 : i + 1);
    end

    next_cycle(); idle(); redirect = 1'b1; cnt_clear = 1'b1;
    expect_out("redir_clear", 1, C_REDIR, 2'b00, 2'b00, 1'b0, 1, 21);
    expect_out("redir_clear", 3, C_REDIR, 2'b00, 2'b00, 1'b0, 1, 15);

    next_cycle(); idle();
    expect_out("cleared", 1, C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);
    expect_out("cleared", 3, C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);

    next_cycle(); idex_mem_read = 1'b1; idex_rd = 5'd8; id_rs = 5'd8;
    expect_out("rst_stall1", 1, C_STALL, 2'b00, 2'b00, 1'b0, 0, 0);
    expect_out("rst_stall1", 3, C_STALL, 2'b00, 2'b00, 1'b0, 0, 0);

    next_cycle(); idle();
    expect_out("rst_stall2", 1, C_RUN,   2'b00, 2'b00, 1'b0, 1, 0);
    expect_out("rst_stall2", 3, C_STALL, 2'b00, 2'b00, 1'b1, 1, 0);

    // Drop reset mid-cycle and sample before any further clock edge.
    @(negedge clk); #1; reset = 1'b0; #1;
    expect_out("async_reset", 1, C_OFF, 2'b00, 2'b00, 1'b0, 0, 0);
    expect_out("async_reset", 3, C_OFF, 2'b00, 2'b00, 1'b0, 0, 0);
    smp = 1'b1; #1; smp = 1'b0;

    next_cycle(); reset = 1'b1;
    expect_out("post_reset", 1, C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);
    expect_out("post_reset", 3, C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);

    next_cycle(); idex_mem_read = 1'b1; idex_rd = 5'd3; id_rs = 5'd3;
    expect_out("post_lu1", 1, C_STALL, 2'b00, 2'b00, 1'b0, 0, 0);
    expect_out("post_lu1", 3, C_STALL, 2'b00, 2'b00, 1'b0, 0, 0);

    next_cycle(); idle();
    expect_out("post_lu2", 1, C_RUN,   2'b00, 2'b00, 1'b0, 1, 0);
    expect_out("post_lu2", 3, C_STALL, 2'b00, 2'b00, 1'b1, 1, 0);

    next_cycle();
    expect_out("post_lu3", 1, C_RUN,   2'b00, 2'b00, 1'b0, 1, 0);
    expect_out("post_lu3", 3, C_STALL, 2'b00, 2'b00, 1'b1, 2, 0);

    next_cycle();
    expect_out("post_lu4", 1, C_RUN, 2'b00, 2'b00, 1'b0, 1, 0);
    expect_out("post_lu4", 3, C_RUN, 2'b00, 2'b00, 1'b0, 3, 0);

    @(negedge clk); #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
